lsu_mem_arbiter: RTL and testbench

Shares the single data-memory port between the LSU load path (port L) and the store-queue drain (port S). It arbitrates round-robin, with one exception: a store always wins over a load to the same word, so a load never overtakes an older store. Issued transactions are tracked in an in-order tag FIFO so that memory responses return to the correct requester. The block sits between the LSU queues and the memory interface.

---
 rtl/lsu_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_lsu_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_arbiter.sv
// Shares one data-memory port between the LSU load path and the store-queue drain.
// Round-robin with a same-word store-first override; an in-order tag FIFO routes responses.
module lsu_mem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int OUTSTANDING = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  ld_req_i,
   input  logic [ADDR_W-1:0]     ld_addr_i,
   output logic                  ld_accept_o,
   output logic                  ld_resp_valid_o,
   output logic [DATA_W-1:0]     ld_resp_data_o,
   input  logic                  st_req_i,
   input  logic [ADDR_W-1:0]     st_addr_i,
   input  logic [DATA_W-1:0]     st_data_i,
   input  logic [DATA_W/8-1:0]   st_wstrb_i,
   output logic                  st_accept_o,
   output logic                  st_ack_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   output logic [DATA_W-1:0]     mem_wdata_o,
   output logic [DATA_W/8-1:0]   mem_wstrb_o,
   input  logic                  mem_accept_i,
   input  logic                  mem_resp_valid_i,
   input  logic [DATA_W-1:0]     mem_resp_data_i,
   output logic                  busy_o,
   output logic                  err_o
);

   localparam int STRB_W = DATA_W / 8;
   localparam int OFF    = (STRB_W > 1) ? $clog2(STRB_W) : 0;
   localparam int PTR_W  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int CNT_W  = $clog2(OUTSTANDING + 1);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(OUTSTANDING - 1);
   localparam logic [CNT_W-1:0] MAX  = CNT_W'(OUTSTANDING);

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } mem_cmd_t;

   logic                   prio;
   logic [OUTSTANDING-1:0] tags;
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [CNT_W-1:0]       count;

   logic     full;
   logic     hit;
   logic     sel_s;
   logic     issue;
   logic     pop;
   logic     stray;
   logic     pop_tag;
   mem_cmd_t cmd;

   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      full  = (count == MAX);
      hit   = ld_req_i & st_req_i &
              (ld_addr_i[ADDR_W-1:OFF] == st_addr_i[ADDR_W-1:OFF]);
      // Store wins when alone, on a same-word collision, or when it holds priority.
      sel_s = st_req_i & (~ld_req_i | hit | prio);

      cmd.we    = sel_s;
      cmd.addr  = sel_s ? st_addr_i  : ld_addr_i;
      cmd.wdata = sel_s ? st_data_i  : '0;
      cmd.wstrb = sel_s ? st_wstrb_i : '0;

      mem_req_o   = rst_i & (ld_req_i | st_req_i) & ~full;
      issue       = mem_req_o & mem_accept_i;
      ld_accept_o = issue & ~sel_s;
      st_accept_o = issue & sel_s;

      mem_we_o    = cmd.we;
      mem_addr_o  = cmd.addr;
      mem_wdata_o = cmd.wdata;
      mem_wstrb_o = cmd.wstrb;

      pop     = mem_resp_valid_i & (count != '0);
      stray   = mem_resp_valid_i & (count == '0);
      pop_tag = tags[rd_ptr];
      busy_o  = (count != '0);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         prio            <= 1'b0;
         tags            <= '0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count           <= '0;
         err_o           <= 1'b0;
         ld_resp_valid_o <= 1'b0;
         ld_resp_data_o  <= '0;
         st_ack_o        <= 1'b0;
      end else begin
         ld_resp_valid_o <= pop & ~pop_tag;
         st_ack_o        <= pop & pop_tag;
         if (pop & ~pop_tag)
            ld_resp_data_o <= mem_resp_data_i;
         if (pop)
            rd_ptr <= bump(rd_ptr);
         if (issue) begin
            tags[wr_ptr] <= sel_s;
            wr_ptr       <= bump(wr_ptr);
            prio         <= ~sel_s;
         end
         if (stray)
            err_o <= 1'b1;
         case ({issue, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Bench for lsu_mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based reference model.
module tb_lsu_mem_arbiter;

   localparam int OUT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ld_req = 1'b0;
   logic [31:0] ld_addr = '0;
   logic        st_req = 1'b0;
   logic [31:0] st_addr = '0;
   logic [31:0] st_data = '0;
   logic [3:0]  st_wstrb = '0;
   logic        mem_accept = 1'b0;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data = '0;

   logic        ld_accept, ld_resp_valid, st_accept, st_ack;
   logic [31:0] ld_resp_data;
   logic        mem_req, mem_we, busy, err;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit          armed = 0;
   bit          q[$];
   bit          m_prio = 0;
   bit          m_err = 0;
   bit          m_ldv = 0;
   bit          m_ack = 0;
   logic [31:0] m_data = '0;
   bit          m_iss = 0;
   bit          m_sel_s = 0;

   lsu_mem_arbiter dut (
      .clk_i(clk), .rst_i(rst_n),
      .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_accept_o(ld_accept),
      .ld_resp_valid_o(ld_resp_valid), .ld_resp_data_o(ld_resp_data),
      .st_req_i(st_req), .st_addr_i(st_addr), .st_data_i(st_data),
      .st_wstrb_i(st_wstrb), .st_accept_o(st_accept), .st_ack_o(st_ack),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
      .mem_accept_i(mem_accept), .mem_resp_valid_i(mem_resp_valid),
      .mem_resp_data_i(mem_resp_data), .busy_o(busy), .err_o(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected outputs for the current cycle, from model state and current inputs.
   task automatic compare();
      bit full, hit, sel_s, req;
      full = (q.size() == OUT);
      hit  = ld_req && st_req && ((ld_addr >> 2) == (st_addr >> 2));
      if (!ld_req && !st_req) sel_s = 0;
      else if (ld_req != st_req) sel_s = st_req;
      else if (hit) sel_s = 1;
      else sel_s = m_prio;
      req = rst_n && (ld_req || st_req) && !full;
      m_sel_s = sel_s;
      m_iss   = req && mem_accept;
      if (!armed) return;
      chk("mem_req", mem_req, req);
      chk("ld_accept", ld_accept, m_iss && !sel_s);
      chk("st_accept", st_accept, m_iss && sel_s);
      if (req) begin
         chk("mem_we", mem_we, sel_s);
         chk("mem_addr", mem_addr, sel_s ? st_addr : ld_addr);
         chk("mem_wdata", mem_wdata, sel_s ? st_data : 32'h0);
         chk("mem_wstrb", mem_wstrb, sel_s ? st_wstrb : 4'h0);
      end
      chk("busy", busy, q.size() != 0);
      chk("err", err, m_err);
      chk("ld_resp_valid", ld_resp_valid, m_ldv);
      chk("st_ack", st_ack, m_ack);
      if (m_ldv) chk("ld_resp_data", ld_resp_data, m_data);
   endtask

   task automatic model_update();
      bit t;
      if (!rst_n) begin
         q.delete();
         m_prio = 0; m_err = 0; m_ldv = 0; m_ack = 0; m_data = '0;
      end else begin
         m_ldv = 0; m_ack = 0;
         if (mem_resp_valid) begin
            if (q.size() > 0) begin
               t = q.pop_front();
               if (!t) begin m_ldv = 1; m_data = mem_resp_data; end
               else m_ack = 1;
            end else m_err = 1;
         end
         if (m_iss) begin
            q.push_back(m_sel_s);
            m_prio = !m_sel_s;
         end
      end
   endtask

   // Entered and left at a falling edge.
   task automatic step();
      #1 compare();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic do_reset();
      ld_req = 0; st_req = 0; mem_resp_valid = 0;
      rst_n = 0;
      step();
      armed = 1;
      step();
      rst_n = 1;
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_ldv", ld_resp_valid, 1'b0);
      chk("rst_ack", st_ack, 1'b0);
      chk("rst_data", ld_resp_data, 32'h0);

      // single load, response three cycles later
      mem_accept = 1; ld_req = 1; ld_addr = 32'h100;
      #1 chk("t1_accept", ld_accept, 1'b1);
      step();
      ld_req = 0;
      chk("t1_busy", busy, 1'b1);
      step(); step();
      mem_resp_valid = 1; mem_resp_data = 32'hDEADBEEF;
      step();
      mem_resp_valid = 0;
      chk("t1_ldv", ld_resp_valid, 1'b1);
      chk("t1_data", ld_resp_data, 32'hDEADBEEF);
      chk("t1_idle", busy, 1'b0);
      step();
      chk("t1_pulse", ld_resp_valid, 1'b0);

      // alternating grants up to full, then response and request in one cycle
      do_reset();
      mem_accept = 1;
      ld_req = 1; ld_addr = 32'h200;
      st_req = 1; st_addr = 32'h300; st_data = 32'h12345678; st_wstrb = 4'hF;
      for (int i = 0; i < 4; i++) begin
         #1 chk("t2_ld_grant", ld_accept, (i % 2) == 0);
         chk("t2_st_grant", st_accept, (i % 2) == 1);
         step();
      end
      #1 chk("t2_full_req", mem_req, 1'b0);
      step();
      mem_resp_valid = 1; mem_resp_data = 32'h11111111;
      #1 chk("t4_no_issue", mem_req, 1'b0);
      step();
      mem_resp_valid = 0;
      chk("t4_pop_ld", ld_resp_valid, 1'b1);
      #1 chk("t4_issue", ld_accept, 1'b1);
      step();
      #1 chk("t4_refull", mem_req, 1'b0);
      step();
      ld_req = 0; st_req = 0;
      mem_resp_valid = 1;
      for (int i = 0; i < 4; i++) begin
         mem_resp_data = 32'hA0 + i;
         step();
         chk("t2_ack_order", st_ack, (i % 2) == 0);
         chk("t2_ld_order", ld_resp_valid, (i % 2) == 1);
      end
      mem_resp_valid = 0;
      chk("t2_drained", busy, 1'b0);

      // same-word hit: store first, then load
      do_reset();
      mem_accept = 1;
      ld_req = 1; ld_addr = 32'h104;
      st_req = 1; st_addr = 32'h107; st_data = 32'hCAFEF00D; st_wstrb = 4'b1000;
      #1 chk("t3_st_first", st_accept, 1'b1);
      chk("t3_st_wstrb", mem_wstrb, 4'b1000);
      step();
      st_req = 0;
      #1 chk("t3_ld_next", ld_accept, 1'b1);
      chk("t3_ld_wstrb", mem_wstrb, 4'b0000);
      chk("t3_ld_we", mem_we, 1'b0);
      step();

      // response and issue together at count 2
      ld_addr = 32'h40; mem_resp_valid = 1; mem_resp_data = 32'h55;
      #1 chk("t5_issue", ld_accept, 1'b1);
      step();
      ld_req = 0; mem_resp_valid = 0;
      chk("t5_ack", st_ack, 1'b1);
      chk("t5_no_ldv", ld_resp_valid, 1'b0);
      mem_resp_valid = 1;
      step();
      chk("t5_ld1", ld_resp_valid, 1'b1);
      step();
      chk("t5_ld2", ld_resp_valid, 1'b1);
      mem_resp_valid = 0;
      chk("t5_idle", busy, 1'b0);

      // stray response
      mem_resp_valid = 1;
      step();
      mem_resp_valid = 0;
      chk("t6_err", err, 1'b1);
      chk("t6_no_ldv", ld_resp_valid, 1'b0);
      chk("t6_no_ack", st_ack, 1'b0);

      // reset with two outstanding
      do_reset();
      chk("t7_err_clr", err, 1'b0);
      mem_accept = 1; ld_req = 1; ld_addr = 32'h8;
      step(); step();
      rst_n = 0;
      #1 chk("t7_rst_req", mem_req, 1'b0);
      chk("t7_rst_acc", ld_accept, 1'b0);
      step();
      rst_n = 1; ld_req = 0;
      chk("t7_busy", busy, 1'b0);
      chk("t7_ldv", ld_resp_valid, 1'b0);
      mem_resp_valid = 1;
      step();
      mem_resp_valid = 0;
      chk("t7_stray_err", err, 1'b1);
      chk("t7_stray_ldv", ld_resp_valid, 1'b0);

      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         rst_n = ($urandom % 500) != 0;
         if (!ld_req && ($urandom % 3 == 0)) begin
            ld_req = 1;
            ld_addr = 32'(($urandom % 4) * 4 + $urandom % 4);
         end
         if (!st_req && ($urandom % 3 == 0)) begin
            st_req = 1;
            st_addr = 32'(($urandom % 4) * 4 + $urandom % 4);
            st_data = $urandom;
            st_wstrb = 4'($urandom);
         end
         mem_accept = ($urandom % 4) != 0;
         mem_resp_valid = (q.size() > 0) ? ($urandom % 3 == 0) : ($urandom % 60 == 0);
         mem_resp_data = $urandom;
         step();
         if (m_iss && !m_sel_s) ld_req = 0;
         if (m_iss && m_sel_s) st_req = 0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
